img_buf_ctrl: RTL and testbench

Frame sequencer for the 3-line image buffer. It sits between the pixel source and the line buffer and gates the pixel handshake. It counts accepted pixels to generate the buffer's per-line `line` strobe and end-of-frame `done` strobe. It also counts window chunks leaving the buffer, so `done` is issued only after the frame has fully drained.

---
 rtl/img_buf_ctrl.sv | 171 +++++++++++++++++
 tb/tb_img_buf_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/img_buf_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | img_buf_ctrl : frame sequencer gating the pixel handshake into the       |
// |                3-line buffer and issuing per-line / end-of-frame strobes |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module img_buf_ctrl #(
   parameter int IMG_W         = 640,
   parameter int IMG_H         = 480,
   parameter int OUT_PER_FRAME = (IMG_H - 2) * IMG_W,
   parameter int TIMEOUT       = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic        src_vld,
   output logic        src_rdy,
   input  logic [23:0] src_data,
   output logic        buf_vld,
   input  logic        buf_rdy,
   output logic [23:0] buf_data,
   output logic        line,
   output logic        done,
   input  logic        out_ok,
   output logic        busy,
   output logic        err_timeout,
   output logic [15:0] frame_cnt
);

   localparam int c_col_w = $clog2(IMG_W);
   localparam int c_row_w = $clog2(IMG_H);
   localparam int c_tmr_w = $clog2(TIMEOUT + 1);

   localparam logic [c_col_w-1:0] c_col_last  = c_col_w'(IMG_W - 1);
   localparam logic [c_row_w-1:0] c_row_last  = c_row_w'(IMG_H - 1);
   localparam logic [c_tmr_w-1:0] c_tmr_lim   = c_tmr_w'(TIMEOUT);
   localparam logic [19:0]        c_out_total = 20'(OUT_PER_FRAME);
   localparam logic [19:0]        c_out_max   = 20'hFFFFF;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t               state_q;
   logic [c_col_w-1:0]   col_q;
   logic [c_row_w-1:0]   row_q;
   logic [19:0]          out_cnt_q;
   logic [c_tmr_w-1:0]   tmr_q;
   logic                 line_q;
   logic                 done_q;
   logic                 busy_q;
   logic                 err_q;
   logic [15:0]          frame_q;
   logic                 abort_pend_q;
   logic                 aborted_q;

   logic                 w_gate;
   logic                 w_acc;
   logic                 w_col_wrap;
   logic                 w_abort_eff;

   // The line cycle is held closed so the pixel after the wrap is not lost
   // while the buffer resets its write address.
   assign w_gate      = (state_q == S_RUN) & ~line_q;
   assign src_rdy     = buf_rdy & w_gate;
   assign buf_vld     = src_vld & w_gate;
   assign buf_data    = src_data;
   assign w_acc       = src_vld & src_rdy;
   assign w_col_wrap  = w_acc & (col_q == c_col_last);
   assign w_abort_eff = abort | abort_pend_q;

   assign line        = line_q;
   assign done        = done_q;
   assign busy        = busy_q;
   assign err_timeout = err_q;
   assign frame_cnt   = frame_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         col_q        <= '0;
         row_q        <= '0;
         out_cnt_q    <= '0;
         tmr_q        <= '0;
         line_q       <= 1'b0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
         err_q        <= 1'b0;
         frame_q      <= '0;
         abort_pend_q <= 1'b0;
         aborted_q    <= 1'b0;
      end else begin
         if ((state_q != S_IDLE) && out_ok && (out_cnt_q != c_out_max)) begin
            out_cnt_q <= out_cnt_q + 20'd1;
         end
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q      <= S_RUN;
                  busy_q       <= 1'b1;
                  col_q        <= '0;
                  row_q        <= '0;
                  out_cnt_q    <= '0;
                  err_q        <= 1'b0;
                  line_q       <= 1'b0;
                  abort_pend_q <= 1'b0;
                  aborted_q    <= 1'b0;
               end
            end
            S_RUN: begin
               if (w_acc) begin
                  col_q <= w_col_wrap ? '0 : col_q + 1'b1;
               end
               line_q <= w_col_wrap;
               if (line_q) begin
                  row_q <= (row_q == c_row_last) ? '0 : row_q + 1'b1;
                  if (w_abort_eff) begin
                     state_q      <= S_DONE;
                     done_q       <= 1'b1;
                     aborted_q    <= 1'b1;
                     abort_pend_q <= 1'b0;
                  end else if (row_q == c_row_last) begin
                     state_q <= S_DRAIN;
                     tmr_q   <= '0;
                  end
               end else if (w_abort_eff) begin
                  // An abort landing on a line-completing pixel lets the line strobe out first.
                  if (w_col_wrap) begin
                     abort_pend_q <= 1'b1;
                  end else begin
                     state_q   <= S_DONE;
                     done_q    <= 1'b1;
                     aborted_q <= 1'b1;
                  end
               end
            end
            S_DRAIN: begin
               if (abort) begin
                  state_q   <= S_DONE;
                  done_q    <= 1'b1;
                  aborted_q <= 1'b1;
               end else if (out_cnt_q == c_out_total) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end else if (tmr_q == c_tmr_lim) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                  err_q   <= 1'b1;
               end else begin
                  tmr_q <= tmr_q + 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               if (!aborted_q) begin
                  frame_q <= frame_q + 16'd1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_img_buf_ctrl.sv
`default_nettype none
// tb_img_buf_ctrl : directed scenarios plus random soak, every cycle compared
// against a pixel/drain counting reference model.
module tb_img_buf_ctrl;

   localparam int W    = 4;
   localparam int H    = 3;
   localparam int NPIX = W * H;
   localparam int OPF  = 4;
   localparam int TO   = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        src_vld = 1'b0;
   logic        src_rdy;
   logic [23:0] src_data = '0;
   logic        buf_vld;
   logic        buf_rdy = 1'b0;
   logic [23:0] buf_data;
   logic        line;
   logic        done;
   logic        out_ok = 1'b0;
   logic        busy;
   logic        err_timeout;
   logic [15:0] frame_cnt;

   img_buf_ctrl #(
      .IMG_W(W), .IMG_H(H), .OUT_PER_FRAME(OPF), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .src_vld(src_vld), .src_rdy(src_rdy), .src_data(src_data),
      .buf_vld(buf_vld), .buf_rdy(buf_rdy), .buf_data(buf_data),
      .line(line), .done(done), .out_ok(out_ok), .busy(busy),
      .err_timeout(err_timeout), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: frame progress expressed as accepted pixels and drain age.
   bit m_busy = 0, m_line = 0, m_done = 0, m_err = 0, m_abort_pend = 0, m_aborted = 0;
   int m_pix = 0, m_outs = 0, m_drain = -1, m_frames = 0;

   // Observations of the DUT for scenario-level checks.
   int n_line = 0, n_acc = 0, n_done = 0, acc_since = 0;
   bit last_done = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input bit i_st, input bit i_ab, input bit i_v, input bit i_r,
                       input bit i_ok, input bit i_rst);
      bit g, acc_m, ab, nline;
      int ocur;
      @(posedge clk);
      #1;
      start = i_st; abort = i_ab; src_vld = i_v; buf_rdy = i_r; out_ok = i_ok; rst = i_rst;
      src_data = 24'($urandom);
      #1;
      g = m_busy && !m_done && (m_drain < 0) && !m_line;
      chk("busy",      32'(busy),        32'(m_busy));
      chk("line",      32'(line),        32'(m_line));
      chk("done",      32'(done),        32'(m_done));
      chk("err",       32'(err_timeout), 32'(m_err));
      chk("frame_cnt", 32'(frame_cnt),   32'(m_frames % 65536));
      chk("src_rdy",   32'(src_rdy),     32'(i_r & g));
      chk("buf_vld",   32'(buf_vld),     32'(i_v & g));
      chk("buf_data",  32'(buf_data),    32'(src_data));
      chk("line_done_excl", 32'(line & done), 32'd0);

      last_done = done;
      if (done) n_done++;
      if (line) begin
         n_line++;
         chk("acc_per_line", acc_since, W);
         acc_since = 0;
      end
      if (src_vld && src_rdy) begin
         n_acc++;
         acc_since++;
      end

      acc_m = i_v && i_r && g;
      if (i_rst) begin
         m_busy = 0; m_line = 0; m_done = 0; m_err = 0; m_abort_pend = 0; m_aborted = 0;
         m_pix = 0; m_outs = 0; m_drain = -1; m_frames = 0; acc_since = 0;
      end else if (!m_busy) begin
         if (i_st) begin
            m_busy = 1; m_pix = 0; m_outs = 0; m_err = 0; m_line = 0;
            m_abort_pend = 0; m_aborted = 0; m_drain = -1; acc_since = 0;
         end
      end else if (m_done) begin
         m_done = 0;
         m_busy = 0;
         if (!m_aborted) m_frames++;
      end else begin
         ocur = m_outs;
         if (i_ok && m_outs < 1048575) m_outs++;
         if (m_drain >= 0) begin
            if (i_ab) begin
               m_done = 1; m_aborted = 1; m_drain = -1;
            end else if (ocur == OPF) begin
               m_done = 1; m_drain = -1;
            end else if (m_drain == TO) begin
               m_done = 1; m_err = 1; m_drain = -1;
            end else begin
               m_drain++;
            end
         end else begin
            ab    = i_ab || m_abort_pend;
            nline = 0;
            if (acc_m) begin
               m_pix++;
               nline = (m_pix % W == 0);
            end
            if (m_line) begin
               if (ab) begin
                  m_done = 1; m_aborted = 1; m_abort_pend = 0;
               end else if (m_pix == NPIX) begin
                  m_drain = 0;
               end
            end else if (ab) begin
               if (nline) m_abort_pend = 1;
               else begin
                  m_done = 1; m_aborted = 1;
               end
            end
            m_line = nline;
         end
      end
   endtask

   task automatic fill_frame();
      for (int i = 0; i < 60 && (m_pix < NPIX || m_line); i++) step(0, 0, 1, 1, 0, 0);
   endtask

   task automatic run_to_idle();
      for (int i = 0; i < 30 && m_busy; i++) step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int k;
      bit tog;

      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 1, 0, 0);

      // Full frame, continuous flow, drained by exactly OPF chunks
      step(1, 0, 0, 1, 0, 0);
      n_line = 0; n_acc = 0; n_done = 0;
      fill_frame();
      chk("t1_lines", n_line, 3);
      chk("t1_accepts", n_acc, NPIX);
      for (int i = 0; i < OPF; i++) step(0, 0, 0, 0, 1, 0);
      run_to_idle();
      chk("t1_done_count", n_done, 1);
      chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);
      chk("t1_idle", 32'(busy), 32'd0);

      // Throttled source and sink
      step(1, 0, 0, 1, 0, 0);
      n_line = 0; n_acc = 0; tog = 0;
      for (int i = 0; i < 200 && (m_pix < NPIX || m_line); i++) begin
         tog = !tog;
         step(0, 0, ($urandom % 2) == 1, tog, 0, 0);
      end
      chk("t2_accepts", n_acc, NPIX);
      chk("t2_lines", n_line, 3);
      for (int i = 0; i < OPF; i++) step(0, 0, 0, 0, 1, 0);
      run_to_idle();
      chk("t2_frame_cnt", 32'(frame_cnt), 32'd2);

      // Drain timeout with only two chunks out
      step(1, 0, 0, 1, 0, 0);
      fill_frame();
      last_done = 0;
      for (k = 0; k < 30; k++) begin
         step(0, 0, 0, 0, k < 2, 0);
         if (last_done) break;
      end
      chk("t3_done_latency", k, 9);
      step(0, 0, 0, 0, 0, 0);
      chk("t3_err_set", 32'(err_timeout), 32'd1);
      chk("t3_frame_cnt", 32'(frame_cnt), 32'd3);
      step(1, 0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      chk("t3_err_cleared", 32'(err_timeout), 32'd0);

      // Abort mid-line after pixel 5
      for (int i = 0; i < 20 && m_pix < 5; i++) step(0, 0, 1, 1, 0, 0);
      step(0, 1, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      chk("t4_done", 32'(last_done), 32'd1);
      run_to_idle();
      chk("t4_frame_cnt", 32'(frame_cnt), 32'd3);
      chk("t4_idle", 32'(busy), 32'd0);

      // Abort coinciding with the line strobe after pixel 8 (restart also re-checks col=0)
      step(1, 0, 0, 1, 0, 0);
      for (int i = 0; i < 40 && !(m_pix == 8 && m_line); i++) step(0, 0, 1, 1, 0, 0);
      step(0, 1, 1, 1, 0, 0);
      chk("t5_line", 32'(line), 32'd1);
      step(0, 0, 0, 1, 0, 0);
      chk("t5_done_next", 32'(last_done), 32'd1);
      chk("t5_line_low", 32'(line), 32'd0);
      run_to_idle();
      chk("t5_frame_cnt", 32'(frame_cnt), 32'd3);

      // Start ignored while busy, then reset in DRAIN
      step(1, 0, 0, 1, 0, 0);
      n_done = 0; n_line = 0;
      for (int i = 0; i < 60 && (m_pix < NPIX || m_line); i++) step(1, 0, 1, 1, 0, 0);
      chk("t6_lines", n_line, 3);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 1, 0, 0);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_frame_cnt", 32'(frame_cnt), 32'd0);
      chk("t6_no_done", n_done, 0);

      // Random soak
      for (int i = 0; i < 3000; i++) begin
         step(($urandom % 8) == 0, ($urandom % 64) == 0, ($urandom % 2) == 1,
              ($urandom % 4) != 0, ($urandom % 2) == 1, ($urandom % 500) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
